pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 27 ++
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the execute/fetch stages and the pipeline hazard controller.
// The master side issues requests, and the slave side (pipe_ctrl) returns redirect, hold and flush controls.
interface pipe_ctrl_if #(
  parameter int unsigned INST_ADDR_W = 32
);
  logic                   ex_jump_req;
  logic [INST_ADDR_W-1:0] ex_jump_addr;
  logic                   ex_hold_req;
  logic                   bus_hold_req;
  logic                   int_req;
  logic                   jump_o;
  logic [INST_ADDR_W-1:0] jump_addr_o;
  logic [1:0]             hold_o;
  logic                   flush_o;
  logic                   int_ack;
  logic [15:0]            stall_cnt;

  modport master (
    output ex_jump_req, ex_jump_addr, ex_hold_req, bus_hold_req, int_req,
    input  jump_o, jump_addr_o, hold_o, flush_o, int_ack, stall_cnt
  );

  modport slave (
    input  ex_jump_req, ex_jump_addr, ex_hold_req, bus_hold_req, int_req,
    output jump_o, jump_addr_o, hold_o, flush_o, int_ack, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates interrupt, jump and hold requests into PC redirect, flush and hold controls.
// All outputs are registered with 1-cycle latency from the sampled request; hold_o freezes the upstream stages.
module pipe_ctrl #(
  parameter int unsigned            INST_ADDR_W  = 32,
  parameter int unsigned            FLUSH_CYCLES = 2,
  parameter logic [INST_ADDR_W-1:0] INT_ADDR     = 32'h0000_0100
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave pif
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH, STALL} state_t;

  state_t                 state, state_nxt;
  logic                   jump_q, jump_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]             hold_q, hold_d;
  logic                   flush_q, flush_d;
  logic                   ack_q, ack_d;
  logic [2:0]             fcnt_q, fcnt_d;
  logic                   cap_vld_q, cap_vld_d;
  logic [INST_ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [15:0]            stall_cnt_q;

  logic       int_ok;
  logic       any_hold;
  logic       jump_now;
  logic       jump_cap;
  logic [1:0] hold_lvl;

  // A bus wait blocks interrupts, and it defers jumps that arrive while already stalled.
  assign int_ok   = pif.int_req && !pif.bus_hold_req;
  assign any_hold = pif.ex_hold_req || pif.bus_hold_req;
  assign jump_now = pif.ex_jump_req && ((state == IDLE) || !pif.bus_hold_req);
  assign jump_cap = cap_vld_q && !pif.bus_hold_req;
  assign hold_lvl = pif.ex_hold_req ? 2'b11 : 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    jump_d     = 1'b0;
    addr_d     = addr_q;
    hold_d     = 2'b00;
    flush_d    = 1'b0;
    ack_d      = 1'b0;
    fcnt_d     = fcnt_q;
    cap_vld_d  = cap_vld_q;
    cap_addr_d = cap_addr_q;
    unique case (state)
      IDLE, STALL: begin
        if (int_ok) begin
          state_nxt = REDIRECT;
          jump_d    = 1'b1;
          flush_d   = 1'b1;
          ack_d     = 1'b1;
          addr_d    = INT_ADDR;
          cap_vld_d = 1'b0;
        end else if (jump_now) begin
          state_nxt = REDIRECT;
          jump_d    = 1'b1;
          flush_d   = 1'b1;
          addr_d    = pif.ex_jump_addr;
          cap_vld_d = 1'b0;
        end else if (jump_cap) begin
          state_nxt = REDIRECT;
          jump_d    = 1'b1;
          flush_d   = 1'b1;
          addr_d    = cap_addr_q;
          cap_vld_d = 1'b0;
        end else begin
          // Only reachable in STALL with the bus waiting: park the jump until the bus frees up.
          if (pif.ex_jump_req) begin
            cap_vld_d  = 1'b1;
            cap_addr_d = pif.ex_jump_addr;
          end
          if (any_hold) begin
            state_nxt = STALL;
            hold_d    = hold_lvl;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      REDIRECT: begin
        state_nxt = FLUSH;
        hold_d    = 2'b10;
        flush_d   = 1'b1;
        fcnt_d    = 3'(FLUSH_CYCLES);
      end
      FLUSH: begin
        if (fcnt_q > 3'd1) begin
          fcnt_d  = fcnt_q - 3'd1;
          hold_d  = 2'b10;
          flush_d = 1'b1;
        end else begin
          fcnt_d = 3'd0;
          if (any_hold) begin
            state_nxt = STALL;
            hold_d    = hold_lvl;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_q     <= 1'b0;
      addr_q     <= '0;
      hold_q     <= 2'b00;
      flush_q    <= 1'b0;
      ack_q      <= 1'b0;
      fcnt_q     <= 3'd0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      jump_q     <= jump_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      flush_q    <= flush_d;
      ack_q      <= ack_d;
      fcnt_q     <= fcnt_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'h0000;
    end else if ((hold_q != 2'b00) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign pif.jump_o      = jump_q;
  assign pif.jump_addr_o = addr_q;
  assign pif.hold_o      = hold_q;
  assign pif.flush_o     = flush_q;
  assign pif.int_ack     = ack_q;
  assign pif.stall_cnt   = stall_cnt_q;
endmodule
